// File: rtl/sysreg_access_unit_pkg.sv
// Shared decode types and helpers for the MTS/MFS system-register instructions.
// Optional counter register is enabled by SYSREG_ACCESS_COUNT_EN (see sysreg_bank).
package sysreg_access_unit_pkg;

  localparam logic [7:0] OP_MTS = 8'h0D;
  localparam logic [7:0] OP_MFS = 8'h0C;

  typedef struct packed {
    logic [2:0] num;
    logic [1:0] pl;
    logic [4:0] group;
  } sysreg_id_t;

  typedef enum logic [1:0] {
    FAULT_ILLEGAL = 2'd0,
    FAULT_UNIMPL  = 2'd1,
    FAULT_PRIV    = 2'd2,
    FAULT_RDONLY  = 2'd3
  } sysreg_fault_e;

  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_CHECK  = 2'd1,
    ACC_ACCESS = 2'd2,
    ACC_RESP   = 2'd3
  } sysreg_acc_state_e;

  localparam logic [4:0] SYSREG_ID_GROUP  = 5'd0;
  localparam logic [2:0] SYSREG_ID_NUM    = 3'd0;
  localparam logic [4:0] SYSREG_CNT_GROUP = 5'd0;
  localparam logic [2:0] SYSREG_CNT_NUM   = 3'd1;

  function automatic logic insn_is_mts(input logic [31:0] insn);
    return (insn[31:23] == 9'd0) && (insn[7:0] == OP_MTS);
  endfunction

  function automatic logic insn_is_mfs(input logic [31:0] insn);
    return (insn[31:23] == 9'd0) && (insn[7:0] == OP_MFS);
  endfunction

  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    return insn[22:18];
  endfunction

  function automatic sysreg_id_t insn_sysreg(input logic [31:0] insn);
    return sysreg_id_t'(insn[17:8]);
  endfunction

endpackage

// File: rtl/sysreg_access_unit_bank.sv
// System register storage: sync write, combinational read, async reset, constant ID register.
// With SYSREG_ACCESS_COUNT_EN, group 0 num 1 is a read-only access counter.
module sysreg_access_unit_bank
  import sysreg_access_unit_pkg::*;
#(
  parameter int              NUM_GROUPS = 4,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] CORE_ID    = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wr_group,
  input  logic [2:0]      wr_num,
  input  logic [XLEN-1:0] wdata,
  input  logic            cnt_inc,
  input  logic [4:0]      rd_group,
  input  logic [2:0]      rd_num,
  output logic [XLEN-1:0] rdata
);

  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic [XLEN-1:0] regs [NUM_GROUPS][8];

  logic wr_hit_id;
  logic rd_hit_id;
  logic wr_in_range;
  logic rd_in_range;

  assign wr_hit_id   = (wr_group == SYSREG_ID_GROUP) && (wr_num == SYSREG_ID_NUM);
  assign rd_hit_id   = (rd_group == SYSREG_ID_GROUP) && (rd_num == SYSREG_ID_NUM);
  assign wr_in_range = 32'(wr_group) < NUM_GROUPS;
  assign rd_in_range = 32'(rd_group) < NUM_GROUPS;

`ifdef SYSREG_ACCESS_COUNT_EN
  logic [XLEN-1:0] cnt;
  logic            wr_hit_cnt;
  logic            rd_hit_cnt;

  assign wr_hit_cnt = (wr_group == SYSREG_CNT_GROUP) && (wr_num == SYSREG_CNT_NUM);
  assign rd_hit_cnt = (rd_group == SYSREG_CNT_GROUP) && (rd_num == SYSREG_CNT_NUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic wr_hit_cnt;
  logic unused_cnt_inc;

  assign wr_hit_cnt     = 1'b0;
  assign unused_cnt_inc = cnt_inc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        for (int n = 0; n < 8; n++) begin
          regs[g][n] <= '0;
        end
      end
    end else if (we && wr_in_range && !wr_hit_id && !wr_hit_cnt) begin
      regs[wr_group[GW-1:0]][wr_num] <= wdata;
    end
  end

  // The counter reads its pre-increment value; the increment lands on the same edge.
  always_comb begin
    rdata = '0;
    if (rd_hit_id) begin
      rdata = CORE_ID;
`ifdef SYSREG_ACCESS_COUNT_EN
    end else if (rd_hit_cnt) begin
      rdata = cnt;
`endif
    end else if (rd_in_range) begin
      rdata = regs[rd_group[GW-1:0]][rd_num];
    end
  end

endmodule

// File: rtl/sysreg_access_unit.sv
// MTS/MFS responder: IDLE -> CHECK -> ACCESS -> RESP, response three cycles after accept.
// Optional access counter via SYSREG_ACCESS_COUNT_EN; response held until rsp_ready.
module sysreg_access_unit
  import sysreg_access_unit_pkg::*;
#(
  parameter int              NUM_GROUPS = 4,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] CORE_ID    = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_insn,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      cur_pl,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_rd,
  output logic            rsp_we,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic [1:0]      rsp_fault_code
);

  sysreg_acc_state_e state;
  sysreg_acc_state_e state_nxt;

  logic [31:0]     insn_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      pl_q;
  logic            fault_q;
  sysreg_fault_e   code_q;

  logic            fault_c;
  sysreg_fault_e   code_c;
  logic            is_mts;
  logic            is_mfs;
  logic            is_ro;
  sysreg_id_t      id;
  logic [XLEN-1:0] bank_rdata;
  logic            bank_we;
  logic            cnt_inc;

  assign is_mts = insn_is_mts(insn_q);
  assign is_mfs = insn_is_mfs(insn_q);
  assign id     = insn_sysreg(insn_q);

`ifdef SYSREG_ACCESS_COUNT_EN
  assign is_ro = ((id.group == SYSREG_ID_GROUP)  && (id.num == SYSREG_ID_NUM)) ||
                 ((id.group == SYSREG_CNT_GROUP) && (id.num == SYSREG_CNT_NUM));
`else
  assign is_ro = (id.group == SYSREG_ID_GROUP) && (id.num == SYSREG_ID_NUM);
`endif

  assign req_ready = (state == ACC_IDLE);
  assign rsp_valid = (state == ACC_RESP);
  assign bank_we   = (state == ACC_ACCESS) && !fault_q && is_mts;
  assign cnt_inc   = (state == ACC_ACCESS) && !fault_q;

  always_comb begin
    fault_c = 1'b0;
    code_c  = FAULT_ILLEGAL;
    if (!(is_mts || is_mfs)) begin
      fault_c = 1'b1;
      code_c  = FAULT_ILLEGAL;
    end else if (32'(id.group) >= NUM_GROUPS) begin
      fault_c = 1'b1;
      code_c  = FAULT_UNIMPL;
    end else if (pl_q < id.pl) begin
      fault_c = 1'b1;
      code_c  = FAULT_PRIV;
    end else if (is_mts && is_ro) begin
      fault_c = 1'b1;
      code_c  = FAULT_RDONLY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC_IDLE:   if (req_valid) state_nxt = ACC_CHECK;
      ACC_CHECK:  state_nxt = ACC_ACCESS;
      ACC_ACCESS: state_nxt = ACC_RESP;
      ACC_RESP:   if (rsp_ready) state_nxt = ACC_IDLE;
      default:    state_nxt = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_q         <= '0;
      wdata_q        <= '0;
      pl_q           <= '0;
      fault_q        <= 1'b0;
      code_q         <= FAULT_ILLEGAL;
      rsp_rd         <= '0;
      rsp_we         <= 1'b0;
      rsp_rdata      <= '0;
      rsp_fault      <= 1'b0;
      rsp_fault_code <= '0;
    end else begin
      case (state)
        ACC_IDLE: begin
          if (req_valid) begin
            insn_q  <= req_insn;
            wdata_q <= req_wdata;
            pl_q    <= cur_pl;
          end
        end
        ACC_CHECK: begin
          fault_q <= fault_c;
          code_q  <= code_c;
        end
        ACC_ACCESS: begin
          rsp_rd         <= insn_rd(insn_q);
          rsp_we         <= !fault_q && is_mfs;
          rsp_rdata      <= (!fault_q && is_mfs) ? bank_rdata : '0;
          rsp_fault      <= fault_q;
          rsp_fault_code <= fault_q ? code_q : 2'd0;
        end
        default: begin
        end
      endcase
    end
  end

  sysreg_access_unit_bank #(
    .NUM_GROUPS (NUM_GROUPS),
    .XLEN       (XLEN),
    .CORE_ID    (CORE_ID)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (bank_we),
    .wr_group (id.group),
    .wr_num   (id.num),
    .wdata    (wdata_q),
    .cnt_inc  (cnt_inc),
    .rd_group (id.group),
    .rd_num   (id.num),
    .rdata    (bank_rdata)
  );

endmodule

// File: tb/tb_sysreg_access_unit.sv
// Directed bench for sysreg_access_unit; counter scenario built when SYSREG_ACCESS_COUNT_EN is defined.
module tb_sysreg_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  cur_pl = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_rd;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_fault_code;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [4:0]  o_rd;
  logic        o_we;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_code;

  always #5 clk = ~clk;

  sysreg_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_insn       (req_insn),
    .req_wdata      (req_wdata),
    .cur_pl         (cur_pl),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rd         (rsp_rd),
    .rsp_we         (rsp_we),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .rsp_fault_code (rsp_fault_code)
  );

  function automatic logic [31:0] mk(input logic mfs, input logic [4:0] rd, input logic [4:0] grp,
                                     input logic [1:0] pl, input logic [2:0] num);
    return {9'd0, rd, num, pl, grp, (mfs ? 8'h0C : 8'h0D)};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait for ready, issue one request, then capture the response (consumed with rsp_ready high).
  task automatic issue(input logic [31:0] insn, input logic [31:0] wdata, input logic [1:0] pl);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_insn  = insn;
    req_wdata = wdata;
    cur_pl    = pl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cur_pl    = ~pl;
    req_wdata = ~wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) lat = 99;
    o_rd = rsp_rd; o_we = rsp_we; o_rdata = rsp_rdata; o_fault = rsp_fault; o_code = rsp_fault_code;
    @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_rd, rsp_we, rsp_fault, rsp_fault_code} !== 9'd0) begin errors++; $display("FAIL reset_rsp_ctrl got %h want 0", {rsp_rd, rsp_we, rsp_fault, rsp_fault_code}); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
  endtask

  task automatic test_write_read();
    issue(32'h0001820D, 32'hDEADBEEF, 2'd0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mts_latency got %0d want 3", lat); end
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL mts_fault got %b want 0", o_fault); end
    checks++; if (o_we !== 1'b0 || o_rdata !== 32'd0) begin errors++; $display("FAIL mts_we_rdata got %b/%h want 0/0", o_we, o_rdata); end
    issue(32'h0015820C, 32'h0, 2'd0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mfs_latency got %0d want 3", lat); end
    checks++; if (o_rd !== 5'd5) begin errors++; $display("FAIL mfs_rd got %0d want 5", o_rd); end
    checks++; if (o_we !== 1'b1 || o_fault !== 1'b0) begin errors++; $display("FAIL mfs_we_fault got %b/%b want 1/0", o_we, o_fault); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mfs_rdata got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_priv();
    issue(32'h0001610D, 32'h11112222, 2'd1);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd2) begin errors++; $display("FAIL priv_fault got %b/%0d want 1/2", o_fault, o_code); end
    checks++; if (o_we !== 1'b0 || o_rdata !== 32'd0) begin errors++; $display("FAIL priv_we_rdata got %b/%h want 0/0", o_we, o_rdata); end
    issue(32'h0001610C, 32'h0, 2'd3);
    checks++; if (o_fault !== 1'b0 || o_we !== 1'b1) begin errors++; $display("FAIL priv_read_ok got %b/%b want 0/1", o_fault, o_we); end
    checks++; if (o_rdata !== 32'd0) begin errors++; $display("FAIL priv_read_rdata got %h want 0", o_rdata); end
  endtask

  task automatic test_unimpl_illegal();
    issue(32'h0000090D, 32'h1, 2'd3);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd1) begin errors++; $display("FAIL unimpl got %b/%0d want 1/1", o_fault, o_code); end
    issue(32'h0000000E, 32'h1, 2'd3);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd0) begin errors++; $display("FAIL illegal_op got %b/%0d want 1/0", o_fault, o_code); end
    issue(32'h0084820C, 32'h0, 2'd3);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd0 || o_we !== 1'b0) begin errors++; $display("FAIL illegal_hi got %b/%0d/%b want 1/0/0", o_fault, o_code, o_we); end
    checks++; if (o_rd !== 5'd1 || o_rdata !== 32'd0) begin errors++; $display("FAIL illegal_rd got %0d/%h want 1/0", o_rd, o_rdata); end
    issue(mk(1'b1, 5'd2, 5'd5, 2'd0, 3'd0), 32'h0, 2'd0);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd1) begin errors++; $display("FAIL unimpl_mfs got %b/%0d want 1/1", o_fault, o_code); end
  endtask

  task automatic test_id_reg();
    issue(32'h0000000D, 32'hFFFF0000, 2'd3);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd3) begin errors++; $display("FAIL id_rdonly got %b/%0d want 1/3", o_fault, o_code); end
    issue(32'h0000000C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'h00000001 || o_we !== 1'b1) begin errors++; $display("FAIL id_read got %h/%b want 00000001/1", o_rdata, o_we); end
  endtask

  task automatic test_back_to_back();
    issue(mk(1'b0, 5'd0, 5'd3, 2'd0, 3'd1), 32'h12345678, 2'd0);
    issue(mk(1'b0, 5'd0, 5'd1, 2'd2, 3'd7), 32'hCAFEF00D, 2'd2);
    issue(mk(1'b1, 5'd9, 5'd3, 2'd0, 3'd1), 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'h12345678 || o_rd !== 5'd9) begin errors++; $display("FAIL b2b_read_a got %h/%0d want 12345678/9", o_rdata, o_rd); end
    issue(mk(1'b1, 5'd31, 5'd1, 2'd2, 3'd7), 32'h0, 2'd3);
    checks++; if (o_rdata !== 32'hCAFEF00D || o_rd !== 5'd31) begin errors++; $display("FAIL b2b_read_b got %h/%0d want cafef00d/31", o_rdata, o_rd); end
    issue(32'h0015820C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_read_c got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_insn = 32'h0015820C; cur_pl = 2'd0;
    @(posedge clk);
    #1 req_insn = 32'h0001820D; req_wdata = 32'h0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got %b want 1", rsp_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rd !== 5'd5 || rsp_we !== 1'b1 ||
          rsp_rdata !== 32'hDEADBEEF || rsp_fault !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v%b r%b rd%0d we%b %h f%b want v1 r0 rd5 we1 deadbeef f0",
                 i, rsp_valid, req_ready, rsp_rd, rsp_we, rsp_rdata, rsp_fault);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r%b v%b want r1 v0", req_ready, rsp_valid); end
    // A second accept during the hold would have overwritten g2n3 with zero.
    issue(32'h0015820C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_no_accept got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_insn = mk(1'b0, 5'd0, 5'd3, 2'd0, 3'd7); req_wdata = 32'h55AA55AA; cur_pl = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_state got r%b v%b want r1 v0", req_ready, rsp_valid); end
    rst = 1'b0;
    issue(mk(1'b1, 5'd4, 5'd3, 2'd0, 3'd7), 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'd0 || o_we !== 1'b1) begin errors++; $display("FAIL abort_read got %h/%b want 0/1", o_rdata, o_we); end
    issue(32'h0015820C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'd0) begin errors++; $display("FAIL abort_bank_clear got %h want 0", o_rdata); end
  endtask

  task automatic test_counter();
    apply_reset();
`ifdef SYSREG_ACCESS_COUNT_EN
    issue(mk(1'b0, 5'd0, 5'd1, 2'd0, 3'd0), 32'h7, 2'd0);
    issue(mk(1'b1, 5'd1, 5'd1, 2'd0, 3'd0), 32'h0, 2'd0);
    issue(32'h0000000C, 32'h0, 2'd0);
    issue(32'h0000800D, 32'h5, 2'd0);
    checks++; if (o_fault !== 1'b1 || o_code !== 2'd3) begin errors++; $display("FAIL cnt_rdonly got %b/%0d want 1/3", o_fault, o_code); end
    issue(32'h0000800C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'd3) begin errors++; $display("FAIL cnt_first got %0d want 3", o_rdata); end
    issue(32'h0000800C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'd4) begin errors++; $display("FAIL cnt_second got %0d want 4", o_rdata); end
`else
    issue(32'h0000800D, 32'h0BADF00D, 2'd0);
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL g0n1_write got fault %b want 0", o_fault); end
    issue(32'h0000800C, 32'h0, 2'd0);
    checks++; if (o_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL g0n1_read got %h want 0badf00d", o_rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priv();
    test_unimpl_illegal();
    test_id_reg();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
